// File: rtl/isa_types.sv
// Shared ISA/bus types: memory access widths, store/load request records and
// the state set of the data-memory access unit.
package isa_types;

  localparam int unsigned MAU_XLEN = 32;

  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } mem_width_t;

  typedef struct packed {
    logic                enable;
    logic [MAU_XLEN-1:0] value;
    logic [MAU_XLEN-1:0] addr;
    mem_width_t          width;
  } mem_write_control_t;

  typedef struct packed {
    logic                enable;
    logic [MAU_XLEN-1:0] addr;
    mem_width_t          width;
  } mem_load_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    RESP_OUT
  } mau_state_t;

  // Natural alignment: halfwords on even bytes, words on word boundaries.
  function automatic logic is_aligned(input mem_width_t w, input logic [1:0] off);
    case (w)
      write_byte:     return 1'b1;
      write_halfword: return ~off[0];
      default:        return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian data bus: byte enables and
// replicated write data for stores, right-aligned extraction for loads.
module mem_lane_align
  import isa_types::*;
(
  input  mem_width_t  i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_val,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_val
);

  logic [31:0] w_shifted;

  // Lane select and load extraction from width and byte offset.
  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    case (i_width)
      write_byte: begin
        o_be       = 4'b0001 << i_off;
        o_wdata    = {4{i_store_val[7:0]}};
        o_load_val = {24'h0, w_shifted[7:0]};
      end
      write_halfword: begin
        o_be       = 4'b0011 << i_off;
        o_wdata    = {2{i_store_val[15:0]}};
        o_load_val = {16'h0, w_shifted[15:0]};
      end
      default: begin
        o_be       = 4'hF;
        o_wdata    = i_store_val;
        o_load_val = w_shifted;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Execute-stage data-memory access unit: takes one store or load per
// transaction, drives a valid/ready word bus and returns right-aligned load data.
module data_mem_access_unit
  import isa_types::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  mem_write_control_t store_ctl,
  input  logic               load_en,
  input  logic [XLEN-1:0]    load_addr,
  input  mem_width_t         load_width,
  output logic               req_ready,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [3:0]         mem_be,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               done,
  output logic               load_valid,
  output logic [XLEN-1:0]    mem_load_val,
  output logic               fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_t        r_state;
  logic              r_req_valid;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_be;
  logic              r_done;
  logic              r_load_valid;
  logic              r_fault;
  logic [XLEN-1:0]   r_load_val;
  logic [CNT_W-1:0]  r_cnt;
  mem_width_t        r_width;
  logic [1:0]        r_off;

  logic              w_accept_store;
  logic              w_accept_load;
  logic              w_conflict;
  mem_width_t        w_req_width;
  logic [XLEN-1:0]   w_req_addr;
  logic              w_aligned;
  mem_width_t        w_la_width;
  logic [1:0]        w_la_off;
  logic [3:0]        w_la_be;
  logic [XLEN-1:0]   w_la_wdata;
  logic [XLEN-1:0]   w_la_load;
  logic              w_idle;

  // Request decode: exactly one of store/load is a legal request.
  always_comb begin
    w_idle         = (r_state == IDLE);
    w_conflict     = store_ctl.enable & load_en;
    w_accept_store = store_ctl.enable & ~load_en;
    w_accept_load  = load_en & ~store_ctl.enable;
    w_req_width    = w_accept_store ? store_ctl.width : load_width;
    w_req_addr     = w_accept_store ? store_ctl.addr  : load_addr;
    w_aligned      = is_aligned(w_req_width, w_req_addr[1:0]);
    // One aligner serves both phases: incoming request in IDLE, captured load otherwise.
    w_la_width     = w_idle ? w_req_width      : r_width;
    w_la_off       = w_idle ? w_req_addr[1:0]  : r_off;
  end

  mem_lane_align u_lane_align (
    .i_width     (w_la_width),
    .i_off       (w_la_off),
    .i_store_val (store_ctl.value),
    .i_rdata     (mem_rdata),
    .o_be        (w_la_be),
    .o_wdata     (w_la_wdata),
    .o_load_val  (w_la_load)
  );

  // Transaction FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_valid  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_done       <= 1'b0;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_load_val   <= '0;
      r_cnt        <= '0;
      r_width      <= write_byte;
      r_off        <= 2'b00;
    end else begin
      r_done       <= 1'b0;
      r_load_valid <= 1'b0;
      r_fault      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_conflict) begin
            r_fault <= 1'b1;
          end else if (w_accept_store | w_accept_load) begin
            if (!w_aligned) begin
              r_fault <= 1'b1;
            end else begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
              r_we        <= w_accept_store;
              r_addr      <= {w_req_addr[XLEN-1:2], 2'b00};
              r_wdata     <= w_accept_store ? w_la_wdata : '0;
              r_be        <= w_accept_store ? w_la_be : 4'hF;
              r_width     <= w_req_width;
              r_off       <= w_req_addr[1:0];
              r_cnt       <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            if (r_we) begin
              r_state <= RESP_OUT;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT_RSP;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_req_valid <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_state      <= RESP_OUT;
            r_done       <= 1'b1;
            r_load_valid <= 1'b1;
            r_load_val   <= w_la_load;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP_OUT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = w_idle;
  assign mem_req_valid = r_req_valid;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_be        = r_be;
  assign done          = r_done;
  assign load_valid    = r_load_valid;
  assign mem_load_val  = r_load_val;
  assign fault         = r_fault;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: a byte-level memory model predicts
// bus requests and completions; a bus model serves requests with random stalls.
module tb_data_mem_access_unit;
  import isa_types::*;

  localparam int unsigned TMO  = 5;
  localparam logic [31:0] BASE = 32'h100;
  localparam int EV_STORE = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_FAULT = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  mem_write_control_t store_ctl;
  logic               load_en;
  logic [31:0]        load_addr;
  mem_width_t         load_width;
  logic               req_ready;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_be;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rdata;
  logic               done;
  logic               load_valid;
  logic [31:0]        mem_load_val;
  logic               fault;

  data_mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .store_ctl     (store_ctl),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_width    (load_width),
    .req_ready     (req_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .done          (done),
    .load_valid    (load_valid),
    .mem_load_val  (mem_load_val),
    .fault         (fault)
  );

  typedef struct {
    int          kind;
    logic [31:0] val;
    int unsigned t0;
    int unsigned lat;
    bit          drop_req;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  ev_t         ev_q[$];
  req_t        req_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [7:0]  ref_mem [64];
  logic [31:0] bus_mem [16];
  logic [31:0] exp_last_load = '0;

  int unsigned k_stall = 0;
  int unsigned k_rsp = 0;
  bit          k_rsp_never = 1'b0;
  bit          stray = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus slave: random ready stall, word memory written through byte enables.
  initial begin
    bit          hs;
    bit          req_active;
    bit          pending;
    int unsigned sc;
    int unsigned rc;
    int unsigned wi;
    int unsigned rd_wi;
    logic        hs_we;
    logic [31:0] hs_addr;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_be;
    req_active = 1'b0;
    pending = 1'b0;
    sc = 0;
    rc = 0;
    rd_wi = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      hs_we = mem_we;
      hs_addr = mem_addr;
      hs_wdata = mem_wdata;
      hs_be = mem_be;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        req_active = 1'b0;
        pending = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (hs) begin
          mem_req_ready = 1'b0;
          req_active = 1'b0;
          wi = (hs_addr - BASE) >> 2;
          if (hs_we) begin
            if (wi < 16)
              for (int b = 0; b < 4; b++)
                if (hs_be[b]) bus_mem[wi][8*b +: 8] = hs_wdata[8*b +: 8];
          end else if (!k_rsp_never) begin
            pending = 1'b1;
            rc = k_rsp;
            rd_wi = wi;
          end
        end
        if (pending) begin
          if (rc == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = (rd_wi < 16) ? bus_mem[rd_wi] : 32'h0;
            pending = 1'b0;
          end else begin
            rc--;
          end
        end
        if (req_active && !mem_req_valid) begin
          req_active = 1'b0;
          mem_req_ready = 1'b0;
        end else if (!req_active && mem_req_valid) begin
          req_active = 1'b1;
          sc = k_stall;
          mem_req_ready = (sc == 0);
        end else if (req_active) begin
          if (sc > 0) sc--;
          mem_req_ready = (sc == 0);
        end
        if (stray) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: bus requests and completion pulses against the scoreboard queues.
  initial begin
    ev_t e;
    int  act_kind;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req_valid) begin
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req actual=addr 0x%08h required=no request (cycle %0d)", mem_addr, cyc);
          end else begin
            chk("req_we", 32'(mem_we), 32'(req_q[0].we));
            chk("req_addr", mem_addr, req_q[0].addr);
            chk("req_be", 32'(mem_be), 32'(req_q[0].be));
            if (req_q[0].we) chk("req_wdata", mem_wdata, req_q[0].wdata);
            if (mem_req_ready) void'(req_q.pop_front());
          end
        end
        if (done || fault || load_valid) begin
          chk("pulse_exclusive", 32'((done & fault) | (load_valid & ~done) | (fault & load_valid)), 32'd0);
          if (ev_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=done%0d lv%0d fault%0d required=none (cycle %0d)",
                     done, load_valid, fault, cyc);
          end else begin
            e = ev_q.pop_front();
            act_kind = fault ? EV_FAULT : (load_valid ? EV_LOAD : EV_STORE);
            chk("resp_kind", 32'(act_kind), 32'(e.kind));
            chk("latency", cyc - e.t0, e.lat);
            if (e.kind == EV_LOAD) begin
              chk("load_val", mem_load_val, e.val);
              exp_last_load = e.val;
            end else begin
              chk("load_val_hold", mem_load_val, exp_last_load);
            end
            if (e.drop_req && req_q.size() != 0) void'(req_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while ((ev_q.size() != 0 || !req_ready) && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 80) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0 (cycle %0d)", ev_q.size(), cyc);
      ev_q.delete();
      req_q.delete();
    end
  endtask

  // tmo: 0 normal, 1 request never accepted, 2 response never returned.
  task automatic issue(input bit st, input bit ld, input logic [31:0] addr,
                       input mem_width_t w, input logic [31:0] val, input int tmo);
    int unsigned n;
    int unsigned off;
    logic [31:0] wd;
    logic [31:0] lv;
    logic [3:0]  be;
    ev_t  e;
    req_t r;
    n = (w == write_byte) ? 1 : ((w == write_halfword) ? 2 : 4);
    off = addr % 4;
    e.t0 = cyc;
    e.val = '0;
    e.drop_req = 1'b0;
    if ((st && ld) || (addr % n) != 0) begin
      e.kind = EV_FAULT;
      e.lat = 1;
      ev_q.push_back(e);
    end else if (st || ld) begin
      be = '0;
      wd = '0;
      lv = '0;
      if (st) begin
        for (int j = 0; j < 4; j++) wd[8*j +: 8] = val[8*(j % n) +: 8];
        for (int i = 0; i < n; i++) begin
          be[off+i] = 1'b1;
          if (tmo == 0) ref_mem[addr - BASE + i] = val[8*i +: 8];
        end
        e.kind = EV_STORE;
        e.lat = 2 + k_stall;
      end else begin
        be = 4'hF;
        for (int i = 0; i < n; i++) lv[8*i +: 8] = ref_mem[addr - BASE + i];
        e.kind = EV_LOAD;
        e.val = lv;
        e.lat = 3 + k_stall + k_rsp;
      end
      if (tmo == 1) begin
        e.kind = EV_FAULT;
        e.lat = TMO + 1;
        e.drop_req = 1'b1;
      end else if (tmo == 2) begin
        e.kind = EV_FAULT;
        e.lat = TMO + 2 + k_stall;
      end
      r.we = st;
      r.addr = addr & 32'hFFFF_FFFC;
      r.wdata = wd;
      r.be = be;
      req_q.push_back(r);
      ev_q.push_back(e);
    end
    store_ctl = '{enable: st, value: val, addr: addr, width: w};
    load_en = ld;
    load_addr = addr;
    load_width = w;
    @(posedge clk);
    #1;
    store_ctl.enable = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({tag, "_load_val"}, mem_load_val, 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    int unsigned op;
    store_ctl = '{enable: 1'b0, value: '0, addr: '0, width: write_byte};
    load_en = 1'b0;
    load_addr = '0;
    load_width = write_byte;
    for (int k = 0; k < 16; k++) begin
      rnd = $urandom;
      bus_mem[k] = rnd;
      for (int b = 0; b < 4; b++) ref_mem[4*k + b] = rnd[8*b +: 8];
    end

    #3;
    chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("post_rst");

    // Directed cases.
    issue(1, 0, 32'h100, write_word, 32'hDEADBEEF, 0);     wait_idle();
    issue(1, 0, 32'h103, write_byte, 32'h000000A5, 0);     wait_idle();
    issue(1, 0, 32'h101, write_halfword, 32'h00001234, 0); wait_idle();
    issue(1, 0, 32'h100, write_word, 32'h80011234, 0);     wait_idle();
    k_rsp = 3;
    issue(0, 1, 32'h102, write_halfword, 32'h0, 0);        wait_idle();
    k_rsp = 0;
    k_stall = 4;
    issue(1, 0, 32'h104, write_word, $urandom, 0);         wait_idle();
    k_stall = 0;
    issue(1, 1, 32'h108, write_word, $urandom, 0);         wait_idle();
    issue(0, 1, 32'h102, write_word, 32'h0, 0);            wait_idle();
    issue(0, 1, 32'h103, write_byte, 32'h0, 0);            wait_idle();

    k_rsp_never = 1'b1;
    issue(0, 1, 32'h100, write_word, 32'h0, 2);            wait_idle();
    chk("tmo_rsp_valid_low", 32'(mem_req_valid), 32'd0);
    k_rsp_never = 1'b0;
    k_stall = 99;
    issue(1, 0, 32'h10C, write_word, 32'h13572468, 1);     wait_idle();
    chk("tmo_req_valid_low", 32'(mem_req_valid), 32'd0);
    k_stall = 0;
    issue(0, 1, 32'h100, write_word, 32'h0, 0);            wait_idle();

    stray = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 9);
      k_stall = $urandom_range(0, 3);
      k_rsp = $urandom_range(0, 3);
      if (op == 9) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else begin
        issue(op < 4 || op == 8, op >= 4, BASE + $urandom_range(0, 63),
              mem_width_t'($urandom_range(0, 2)), $urandom, 0);
        wait_idle();
      end
    end
    k_stall = 0;
    k_rsp = 0;

    // Reset while a request is on the bus.
    k_stall = 99;
    issue(1, 0, 32'h110, write_word, 32'hCAFEF00D, 1);
    chk("pre_rst_req_valid", 32'(mem_req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_in_req");
    ev_q.delete();
    req_q.delete();
    exp_last_load = '0;
    k_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while waiting for read data; the late response must be ignored.
    k_rsp = 6;
    issue(0, 1, 32'h100, write_word, 32'h0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_in_wait");
    ev_q.delete();
    req_q.delete();
    exp_last_load = '0;
    k_rsp = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    stray = 1'b0;
    issue(0, 1, 32'h104, write_halfword, 32'h0, 0);        wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
